// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver.
// Deframes 11-bit device-to-host frames from the raw PS/2 pins, assembles the
// 3-byte movement packet and presents it as per-axis magnitude + direction.
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity checking; a
// failing byte is discarded, frame_err pulses and the packet restarts).
//
// Frame FSM
//   state     | meaning
//   F_START   | waiting for a start bit (0) on a fall_tick
//   F_DATA    | shifting in 8 data bits, LSB first
//   F_PARITY  | sampling the parity bit
//   F_STOP    | sampling the stop bit, byte complete or discarded
//
// Packet FSM
//   state     | meaning
//   P_B0      | waiting for a header byte (bit3 = 1)
//   P_B1      | waiting for the X movement byte
//   P_B2      | waiting for the Y movement byte, commits on arrival

module ps2_mouse_packet_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SAT_MAG        = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] vx,
    output logic [9:0] vy,
    output logic       dx,
    output logic       dy,
    output logic       mousepush,
    output logic       mouseright,
    output logic       mouseReady,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {F_START, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {P_B0, P_B1, P_B2} pkt_state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          r_fall;
    logic [TW-1:0] r_to_cnt;

    frame_state_t  r_fstate, w_fstate_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic          w_byte_done;
    logic          w_stop_err;
    logic          r_byte_valid;
    logic [7:0]    r_byte;

    pkt_state_t    r_pstate, w_pstate_nxt;
    logic          w_store_hdr;
    logic          w_store_x;
    logic          w_commit;
    logic          w_sync_err;
    logic [1:0]    r_btn;
    logic          r_sx, r_sy, r_ox, r_oy;
    logic [7:0]    r_xbyte;

    logic          w_busy;
    logic          w_timeout;
    logic          w_din;
    logic          w_par_err_q;
    logic [8:0]    w_xval, w_yval;
    logic [9:0]    w_xmag, w_ymag;

`ifdef PS2_PARITY_CHECK_EN
    logic          r_par, w_par_nxt;
    logic          w_par_err;
    logic          r_par_err;
    assign w_par_err_q = r_par_err;
`else
    assign w_par_err_q = 1'b0;
`endif

    assign w_din = r_dat_sync[1];

    // Two-flop synchronizers; idle bus level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    // Glitch filter on ps2_clk; emits fall_tick when the filtered level drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_sync[1] == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_sync[1];
                r_filt_cnt <= '0;
                r_fall     <= r_filt;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // Inactivity timer: cleared by every fall_tick, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_fall) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // An idle bus never times out, and a fall_tick in the same cycle wins.
    assign w_busy    = (r_fstate != F_START) || (r_pstate != P_B0);
    assign w_timeout = w_busy && (r_to_cnt == TW'(TIMEOUT_CYCLES)) && !r_fall;

    // Frame FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fstate     <= F_START;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_fstate     <= w_fstate_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_done;
            if (w_byte_done) begin
                r_byte <= r_shift;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    // Parity bit capture and registered parity-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            r_par     <= w_par_nxt;
            r_par_err <= w_par_err;
        end
    end
`endif

    // Frame FSM next-state: walks start, data, parity and stop on fall_ticks.
    always_comb begin
        w_fstate_nxt  = r_fstate;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_byte_done   = 1'b0;
        w_stop_err    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        w_par_nxt     = r_par;
        w_par_err     = 1'b0;
`endif
        if (w_timeout) begin
            w_fstate_nxt  = F_START;
            w_bit_idx_nxt = '0;
        end else if (r_fall) begin
            case (r_fstate)
                F_START: begin
                    if (!w_din) begin
                        w_fstate_nxt  = F_DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
                F_DATA: begin
                    w_shift_nxt = {w_din, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_fstate_nxt = F_PARITY;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
                F_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    w_par_nxt = w_din;
`endif
                    w_fstate_nxt = F_STOP;
                end
                F_STOP: begin
                    w_fstate_nxt  = F_START;
                    w_bit_idx_nxt = '0;
                    if (!w_din) begin
                        w_stop_err = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{r_shift, r_par})) begin
                        w_par_err = 1'b1;
`endif
                    end else begin
                        w_byte_done = 1'b1;
                    end
                end
                default: w_fstate_nxt = F_START;
            endcase
        end
    end

    // Packet FSM state register and packet field storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate <= P_B0;
            r_btn    <= '0;
            r_sx     <= 1'b0;
            r_sy     <= 1'b0;
            r_ox     <= 1'b0;
            r_oy     <= 1'b0;
            r_xbyte  <= '0;
        end else begin
            r_pstate <= w_pstate_nxt;
            if (w_store_hdr) begin
                r_btn <= r_byte[1:0];
                r_sx  <= r_byte[4];
                r_sy  <= r_byte[5];
                r_ox  <= r_byte[6];
                r_oy  <= r_byte[7];
            end
            if (w_store_x) begin
                r_xbyte <= r_byte;
            end
        end
    end

    // Packet FSM next-state: header sync check, X, Y and commit.
    always_comb begin
        w_pstate_nxt = r_pstate;
        w_store_hdr  = 1'b0;
        w_store_x    = 1'b0;
        w_commit     = 1'b0;
        w_sync_err   = 1'b0;
        if (w_timeout || w_par_err_q) begin
            w_pstate_nxt = P_B0;
        end else if (r_byte_valid) begin
            case (r_pstate)
                P_B0: begin
                    if (r_byte[3]) begin
                        w_store_hdr  = 1'b1;
                        w_pstate_nxt = P_B1;
                    end else begin
                        w_sync_err = 1'b1;
                    end
                end
                P_B1: begin
                    w_store_x    = 1'b1;
                    w_pstate_nxt = P_B2;
                end
                P_B2: begin
                    w_commit     = 1'b1;
                    w_pstate_nxt = P_B0;
                end
                default: w_pstate_nxt = P_B0;
            endcase
        end
    end

    // 9-bit two's complement axis values to magnitude; 512 - v is |v| for negatives.
    assign w_xval = {r_sx, r_xbyte};
    assign w_yval = {r_sy, r_byte};

    always_comb begin
        w_xmag = r_sx ? 10'(10'd512 - {1'b0, w_xval}) : {2'b00, r_xbyte};
        w_ymag = r_sy ? 10'(10'd512 - {1'b0, w_yval}) : {2'b00, r_byte};
        if (r_ox) w_xmag = 10'(SAT_MAG);
        if (r_oy) w_ymag = 10'(SAT_MAG);
    end

    // Output registers: levels update on commit, pulses for ready and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vx         <= '0;
            vy         <= '0;
            dx         <= 1'b0;
            dy         <= 1'b0;
            mousepush  <= 1'b0;
            mouseright <= 1'b0;
            mouseReady <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            mouseReady <= w_commit;
            frame_err  <= w_timeout | w_stop_err | w_sync_err | w_par_err_q;
            if (w_commit) begin
                vx         <= w_xmag;
                vy         <= w_ymag;
                dx         <= r_sx;
                dy         <= r_sy;
                mousepush  <= r_btn[0];
                mouseright <= r_btn[1];
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Testbench for ps2_mouse_packet_rx: directed spec scenarios plus random packets.
module tb_ps2_mouse_packet_rx;

    localparam int FL   = 4;
    localparam int TO   = 400;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] vx, vy;
    logic       dx, dy, mousepush, mouseright, mouseReady, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;

    ps2_mouse_packet_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .SAT_MAG(255)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .vx(vx), .vy(vy), .dx(dx), .dy(dy),
        .mousepush(mousepush), .mouseright(mouseright),
        .mouseReady(mouseReady), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of the pulse outputs; a one-cycle pulse adds exactly 1.
    always @(negedge clk) begin
        if (mouseReady === 1'b1) rdy_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // Device-to-host frame; nbits < 11 sends a truncated frame.
    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                             input bit bad_stop = 1'b0, input int nbits = 11,
                             input bit glitch = 1'b0);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (glitch) begin
                repeat (HALF / 2) @(posedge clk);
                ps2_clk = 1'b0;
                repeat (2) @(posedge clk);
                ps2_clk = 1'b1;
                repeat (HALF / 2 - 2) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    // Full packet; expectations come from the packet rules in plain arithmetic.
    task automatic test_packet(input logic [7:0] h, input logic [7:0] x,
                               input logic [7:0] y, input bit glitch = 1'b0);
        int r0, e0, xs, ys, ex, ey;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(h, 0, 0, 11, glitch);
        send_byte(x, 0, 0, 11, glitch);
        send_byte(y, 0, 0, 11, glitch);
        @(negedge clk);
        xs = h[4] ? int'(x) - 256 : int'(x);
        ys = h[5] ? int'(y) - 256 : int'(y);
        ex = h[6] ? 255 : (xs < 0 ? -xs : xs);
        ey = h[7] ? 255 : (ys < 0 ? -ys : ys);
        n_cmp++;
        if (rdy_cnt - r0 !== 1) begin
            n_err++;
            $display("FAIL pkt_ready h=%h x=%h y=%h: got %0d pulses, want 1", h, x, y, rdy_cnt - r0);
        end
        n_cmp++;
        if (err_cnt - e0 !== 0) begin
            n_err++;
            $display("FAIL pkt_no_err h=%h: got %0d frame_err, want 0", h, err_cnt - e0);
        end
        n_cmp++;
        if (vx !== 10'(ex) || dx !== h[4]) begin
            n_err++;
            $display("FAIL pkt_x h=%h x=%h: got vx=%0d dx=%b, want vx=%0d dx=%b", h, x, vx, dx, ex, h[4]);
        end
        n_cmp++;
        if (vy !== 10'(ey) || dy !== h[5]) begin
            n_err++;
            $display("FAIL pkt_y h=%h y=%h: got vy=%0d dy=%b, want vy=%0d dy=%b", h, y, vy, dy, ey, h[5]);
        end
        n_cmp++;
        if (mousepush !== h[0] || mouseright !== h[1]) begin
            n_err++;
            $display("FAIL pkt_btn h=%h: got push=%b right=%b, want %b %b", h, mousepush, mouseright, h[0], h[1]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({vx, vy, dx, dy, mousepush, mouseright, mouseReady, frame_err} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got vx=%0d vy=%0d dx=%b dy=%b push=%b right=%b rdy=%b err=%b, want all 0",
                     vx, vy, dx, dy, mousepush, mouseright, mouseReady, frame_err);
        end
        n_cmp++;
        if (rdy_cnt !== 0 || err_cnt !== 0) begin
            n_err++;
            $display("FAIL reset_pulses: got rdy=%0d err=%0d, want 0 0", rdy_cnt, err_cnt);
        end
    endtask

    task automatic test_directed();
        test_packet(8'h09, 8'h05, 8'h03);
        test_packet(8'h38, 8'hFB, 8'h00);
        test_packet(8'h58, 8'h10, 8'h01);
        test_packet(8'hB9, 8'h7F, 8'h80);
    endtask

    task automatic test_glitch();
        test_packet(8'h2B, 8'h44, 8'hF0, 1'b1);
    endtask

    task automatic test_sync();
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(8'h05);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
            n_err++;
            $display("FAIL sync_stray: got err=%0d rdy=%0d, want 1 0", err_cnt - e0, rdy_cnt - r0);
        end
        test_packet(8'h08, 8'h02, 8'h02);
    endtask

    task automatic test_stop_err();
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(8'h09, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
            n_err++;
            $display("FAIL stop_err: got err=%0d rdy=%0d, want 1 0", err_cnt - e0, rdy_cnt - r0);
        end
        test_packet(8'h19, 8'h80, 8'h7F);
    endtask

    task automatic test_timeout();
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(8'h09);
        send_byte(8'h05);
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1 || rdy_cnt - r0 !== 0) begin
            n_err++;
            $display("FAIL timeout_pkt: got err=%0d rdy=%0d, want 1 0", err_cnt - e0, rdy_cnt - r0);
        end
        repeat (2 * TO) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_err++;
            $display("FAIL timeout_idle: got err=%0d, want 1", err_cnt - e0);
        end
        e0 = err_cnt;
        send_byte(8'hAA, 1'b0, 1'b0, 4);
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (err_cnt - e0 !== 1) begin
            n_err++;
            $display("FAIL timeout_frame: got err=%0d, want 1", err_cnt - e0);
        end
        test_packet(8'h0A, 8'h33, 8'hCC);
    endtask

    task automatic test_parity();
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(8'h09);
        send_byte(8'h05, 1'b1);
        send_byte(8'h03);
        @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
        n_cmp++;
        if (err_cnt - e0 !== 2 || rdy_cnt - r0 !== 0) begin
            n_err++;
            $display("FAIL parity_on: got err=%0d rdy=%0d, want 2 0", err_cnt - e0, rdy_cnt - r0);
        end
`else
        n_cmp++;
        if (err_cnt - e0 !== 0 || rdy_cnt - r0 !== 1) begin
            n_err++;
            $display("FAIL parity_off: got err=%0d rdy=%0d, want 0 1", err_cnt - e0, rdy_cnt - r0);
        end
        n_cmp++;
        if (vx !== 10'd5 || vy !== 10'd3 || mousepush !== 1'b1) begin
            n_err++;
            $display("FAIL parity_off_val: got vx=%0d vy=%0d push=%b, want 5 3 1", vx, vy, mousepush);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int r0, e0;
        test_packet(8'h0B, 8'h21, 8'h12);
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_byte(8'h09);
        send_byte(8'h05);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vx, vy, dx, dy, mousepush, mouseright} !== 24'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got vx=%0d vy=%0d push=%b, want 0", vx, vy, mousepush);
        end
        send_byte(8'h03);
        repeat (2 * TO) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdy_cnt - r0 !== 0 || err_cnt - e0 !== 1) begin
            n_err++;
            $display("FAIL reset_mid_pulses: got rdy=%0d err=%0d, want 0 1", rdy_cnt - r0, err_cnt - e0);
        end
        test_packet(8'h3C, 8'hFF, 8'h01);
    endtask

    task automatic test_random();
        logic [7:0] h, x, y;
        for (int i = 0; i < 12; i++) begin
            h = 8'($urandom_range(0, 255));
            h[3] = 1'b1;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            test_packet(h, x, y);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        test_reset();
        test_directed();
        test_glitch();
        test_sync();
        test_stop_err();
        test_timeout();
        test_parity();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
